// File: rtl/note_spawn_scheduler_if.sv
// -----------------------------------------------------------------------------
// note_spawn_scheduler_if
//   Bundles the two streaming handshakes of the note spawn scheduler:
//     chart stream (chart_valid/chart_col in, chart_ready out)
//     note track   (spawn_valid/spawn_col out, spawn_ready in)
//   Modports:
//     master : the scheduler side (drives spawn_*, chart_ready)
//     slave  : the environment side (chart source and falling-note track)
// -----------------------------------------------------------------------------
interface note_spawn_scheduler_if;
  logic       chart_valid;
  logic [1:0] chart_col;
  logic       chart_ready;
  logic       spawn_valid;
  logic [1:0] spawn_col;
  logic       spawn_ready;

  modport master (
    input  chart_valid, chart_col, spawn_ready,
    output chart_ready, spawn_valid, spawn_col
  );

  modport slave (
    output chart_valid, chart_col, spawn_ready,
    input  chart_ready, spawn_valid, spawn_col
  );
endinterface

// File: rtl/note_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// note_spawn_scheduler
//   Sequences note spawning for a 4-column rhythm game. Every TICKS_PER_NOTE
//   unpaused beat ticks it picks a column (LFSR source or chart stream) and
//   offers one note to the falling-note track over a valid/ready handshake.
//   In random mode a column may repeat at most MAX_REPEAT times in a row.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     start_i         pulse, begin a song (IDLE/DONE only)
//     abort_i         pulse, return to IDLE from any state
//     mode_i          0 = random, 1 = chart (latched on start)
//     pause_i         level, beat ticks ignored while high
//     beat_tick_i     beat pulse
//     rand_col_i      random column source, [1:0] used
//     bus             chart and spawn handshakes (master modport)
//     busy_o          high in WAIT_TICK, PICK, ISSUE
//     done_o          high in DONE
//     late_o          sticky tick-overrun flag
//     note_count_o    notes accepted since the last start
// -----------------------------------------------------------------------------
module note_spawn_scheduler #(
  parameter int NUM_NOTES      = 64,
  parameter int TICKS_PER_NOTE = 4,
  parameter int MAX_REPEAT     = 2,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 mode_i,
  input  logic                 pause_i,
  input  logic                 beat_tick_i,
  input  logic [3:0]           rand_col_i,
  note_spawn_scheduler_if.master bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 late_o,
  output logic [CNT_W-1:0]     note_count_o
);

  localparam int TW = (TICKS_PER_NOTE > 1) ? $clog2(TICKS_PER_NOTE) : 1;
  localparam int RW = $clog2(MAX_REPEAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_PICK  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic             mode_q;
  logic [TW-1:0]    tick_cnt_q;
  logic [1:0]       last_col_q;
  logic [RW-1:0]    rep_cnt_q;
  logic [1:0]       spawn_col_q;
  logic             spawn_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             late_q;
  logic [CNT_W-1:0] note_count_q;

  logic             tick_s;
  logic [1:0]       rand_col_d;
  logic [RW-1:0]    rep_cnt_d;
  logic [CNT_W-1:0] note_count_d;

  assign tick_s       = beat_tick_i & ~pause_i;
  assign note_count_d = note_count_q + CNT_W'(1);

  // Random column choice: bump to the next column once the repeat limit is hit.
  always_comb begin
    rand_col_d = rand_col_i[1:0];
    if ((rand_col_i[1:0] == last_col_q) && (rep_cnt_q == RW'(MAX_REPEAT))) begin
      rand_col_d = rand_col_i[1:0] + 2'd1;
    end else begin
      rand_col_d = rand_col_i[1:0];
    end
  end

  // Repeat counter update applied when the offered note is accepted.
  always_comb begin
    rep_cnt_d = RW'(1);
    if (spawn_col_q == last_col_q) begin
      if (rep_cnt_q == RW'(MAX_REPEAT)) begin
        rep_cnt_d = rep_cnt_q;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end else begin
      rep_cnt_d = RW'(1);
    end
  end

  // Main FSM with registered outputs; abort outranks start, start outranks the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      tick_cnt_q    <= '0;
      last_col_q    <= 2'd0;
      rep_cnt_q     <= '0;
      spawn_col_q   <= 2'd0;
      spawn_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      late_q        <= 1'b0;
      note_count_q  <= '0;
    end else if (abort_i) begin
      // note_count and late deliberately survive an abort
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      last_col_q    <= 2'd0;
      rep_cnt_q     <= '0;
      spawn_col_q   <= 2'd0;
      spawn_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q      <= S_WAIT;
            mode_q       <= mode_i;
            tick_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            late_q       <= 1'b0;
            note_count_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        S_WAIT: begin
          if (tick_s) begin
            if (tick_cnt_q == TW'(TICKS_PER_NOTE - 1)) begin
              tick_cnt_q <= '0;
              state_q    <= S_PICK;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
        end
        S_PICK: begin
          if (tick_s) begin
            late_q <= 1'b1;
          end
          if (!mode_q) begin
            spawn_col_q   <= rand_col_d;
            spawn_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end else if (bus.chart_valid) begin
            spawn_col_q   <= bus.chart_col;
            spawn_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tick_s) begin
            late_q <= 1'b1;
          end
          if (bus.spawn_ready) begin
            spawn_valid_q <= 1'b0;
            note_count_q  <= note_count_d;
            rep_cnt_q     <= rep_cnt_d;
            last_col_q    <= spawn_col_q;
            if (note_count_d == CNT_W'(NUM_NOTES)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        default: begin
          state_q       <= S_IDLE;
          spawn_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

  // chart_ready is a pure decode of registered state so it follows PICK exactly.
  assign bus.chart_ready = (state_q == S_PICK) && mode_q;
  assign bus.spawn_valid = spawn_valid_q;
  assign bus.spawn_col   = spawn_col_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign late_o          = late_q;
  assign note_count_o    = note_count_q;

endmodule

// File: tb/tb_note_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_note_spawn_scheduler
//   Directed bench for note_spawn_scheduler with NUM_NOTES=3, TICKS_PER_NOTE=4,
//   MAX_REPEAT=2. Inputs change 1 time unit after the rising edge; outputs are
//   sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_note_spawn_scheduler;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i, abort_i, mode_i, pause_i, beat_tick_i;
  logic [3:0]       rand_col_i;
  logic             busy_o, done_o, late_o;
  logic [CNT_W-1:0] note_count_o;

  int checks = 0;
  int errors = 0;

  note_spawn_scheduler_if bus_if ();

  note_spawn_scheduler #(
    .NUM_NOTES(3), .TICKS_PER_NOTE(4), .MAX_REPEAT(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
    .pause_i(pause_i), .beat_tick_i(beat_tick_i), .rand_col_i(rand_col_i),
    .bus(bus_if),
    .busy_o(busy_o), .done_o(done_o), .late_o(late_o),
    .note_count_o(note_count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    beat_tick_i = 1'b1;
    step();
    beat_tick_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_start(input logic m);
    mode_i  = m;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // One random-mode note with spawn_ready already high: 4 ticks, PICK, ISSUE, accept.
  task automatic rand_note(input string tag, input logic [1:0] exp_col);
    ticks(4);
    step();
    chk({tag, "_valid"}, {31'd0, bus_if.spawn_valid}, 32'd1);
    chk({tag, "_col"}, {30'd0, bus_if.spawn_col}, {30'd0, exp_col});
    step();
  endtask

  initial begin
    logic [1:0] seq [6];
    seq = '{2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0};
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0; pause_i = 1'b0;
    beat_tick_i = 1'b0; rand_col_i = 4'd1;
    bus_if.chart_valid = 1'b0; bus_if.chart_col = 2'd0; bus_if.spawn_ready = 1'b1;
    step(); step();

    // Reset state
    chk("rst_valid", {31'd0, bus_if.spawn_valid}, 32'd0);
    chk("rst_chart_ready", {31'd0, bus_if.chart_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_late", {31'd0, late_o}, 32'd0);
    chk("rst_count", {24'd0, note_count_o}, 32'd0);
    rst_n = 1'b1;
    step();

    // Random mode: 8 ticks give exactly 2 spawns, valid 2 cycles after the 4th tick
    pulse_start(1'b0);
    chk("t2_busy", {31'd0, busy_o}, 32'd1);
    ticks(3);
    chk("t2_no_early", {31'd0, bus_if.spawn_valid}, 32'd0);
    tick();
    chk("t2_pick_cycle", {31'd0, bus_if.spawn_valid}, 32'd0);
    step();
    chk("t2_valid1", {31'd0, bus_if.spawn_valid}, 32'd1);
    chk("t2_col1", {30'd0, bus_if.spawn_col}, 32'd1);
    step();
    chk("t2_drop1", {31'd0, bus_if.spawn_valid}, 32'd0);
    chk("t2_count1", {24'd0, note_count_o}, 32'd1);
    ticks(3);
    chk("t2_no_mid", {31'd0, bus_if.spawn_valid}, 32'd0);
    tick();
    step();
    chk("t2_valid2", {31'd0, bus_if.spawn_valid}, 32'd1);
    step();
    chk("t2_count2", {24'd0, note_count_o}, 32'd2);
    chk("t2_late", {31'd0, late_o}, 32'd0);

    // Reset while a note is being offered
    bus_if.spawn_ready = 1'b0;
    ticks(4);
    step();
    chk("t1_in_issue", {31'd0, bus_if.spawn_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_valid", {31'd0, bus_if.spawn_valid}, 32'd0);
    chk("t1_busy", {31'd0, busy_o}, 32'd0);
    chk("t1_count", {24'd0, note_count_o}, 32'd0);
    chk("t1_col", {30'd0, bus_if.spawn_col}, 32'd0);
    step();
    rst_n = 1'b1;
    bus_if.spawn_ready = 1'b1;
    step();

    // Repeat limiting across two songs: 3,3,0 then 3,3,0
    rand_col_i = 4'd3;
    pulse_start(1'b0);
    for (int i = 0; i < 6; i++) begin
      rand_note($sformatf("t3_n%0d", i), seq[i]);
      if (i == 2 || i == 5) begin
        chk("t6_done", {31'd0, done_o}, 32'd1);
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_count", {24'd0, note_count_o}, 32'd3);
        if (i == 2) pulse_start(1'b0);
      end
    end
    ticks(4);
    chk("t6_idle_in_done", {31'd0, bus_if.spawn_valid}, 32'd0);

    // Chart mode: stall in PICK, then column 2
    bus_if.spawn_ready = 1'b0;
    pulse_start(1'b1);
    chk("t4_done_clr", {31'd0, done_o}, 32'd0);
    ticks(4);
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_ready", {31'd0, bus_if.chart_ready}, 32'd1);
      chk("t4_stall_valid", {31'd0, bus_if.spawn_valid}, 32'd0);
      step();
    end
    bus_if.chart_valid = 1'b1;
    bus_if.chart_col   = 2'd2;
    step();
    bus_if.chart_valid = 1'b0;
    bus_if.chart_col   = 2'd0;
    chk("t4_valid", {31'd0, bus_if.spawn_valid}, 32'd1);
    chk("t4_col", {30'd0, bus_if.spawn_col}, 32'd2);
    chk("t4_ready_low", {31'd0, bus_if.chart_ready}, 32'd0);

    // Overrun while the track holds off
    tick();
    chk("t5_late", {31'd0, late_o}, 32'd1);
    tick();
    chk("t5_count_hold", {24'd0, note_count_o}, 32'd0);
    chk("t5_valid_hold", {31'd0, bus_if.spawn_valid}, 32'd1);
    chk("t5_col_hold", {30'd0, bus_if.spawn_col}, 32'd2);
    bus_if.spawn_ready = 1'b1;
    step();
    chk("t5_count", {24'd0, note_count_o}, 32'd1);
    chk("t5_drop", {31'd0, bus_if.spawn_valid}, 32'd0);
    chk("t5_late_sticky", {31'd0, late_o}, 32'd1);

    // Pause masks ticks
    pause_i = 1'b1;
    ticks(4);
    pause_i = 1'b0;
    step();
    chk("pause_no_pick", {31'd0, bus_if.chart_ready}, 32'd0);

    // Abort from PICK drops chart_ready and busy, keeps count and late
    ticks(4);
    chk("ab_pick", {31'd0, bus_if.chart_ready}, 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("ab_chart_ready", {31'd0, bus_if.chart_ready}, 32'd0);
    chk("ab_busy", {31'd0, busy_o}, 32'd0);
    chk("ab_count", {24'd0, note_count_o}, 32'd1);
    chk("ab_late", {31'd0, late_o}, 32'd1);

    // Start and abort together stays in IDLE
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("sa_busy", {31'd0, busy_o}, 32'd0);
    chk("sa_late", {31'd0, late_o}, 32'd1);
    pulse_start(1'b0);
    chk("rs_busy", {31'd0, busy_o}, 32'd1);
    chk("rs_late", {31'd0, late_o}, 32'd0);
    chk("rs_count", {24'd0, note_count_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
